// File: rtl/ila_seq.sv
`default_nettype none
// ============================================================================
// ila_seq : JESD204B ILAS generator, one lane, 4 octets per clock
// Rev 1.0
// ============================================================================
module ila_seq #(
    parameter int F      = 2,
    parameter int K      = 16,
    parameter int NUM_MF = 4
) (
    input  logic         CLK,
    input  logic         RST_n,
    input  logic         EN,
    input  logic [111:0] CFG,
    output logic [31:0]  TX_DATA,
    output logic [3:0]   TX_K,
    output logic         TX_VALID,
    output logic [3:0]   ILA_ME,
    output logic         ILA_RDY
);

    localparam int MF_OCT   = F * K;
    localparam int MF_BEATS = MF_OCT / 4;
    localparam int BW       = $clog2(MF_BEATS);
    localparam int MW       = $clog2(NUM_MF);
    localparam int IW       = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [BW-1:0] B_LAST = BW'(MF_BEATS - 1);
    localparam logic [MW-1:0] M_LAST = MW'(NUM_MF - 1);
    localparam logic [IW-1:0] I_LAST = IW'(MF_OCT - 1);

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] b_q, b_d;
    logic [MW-1:0] m_q, m_d;
    logic [31:0]   data_q, data_d;
    logic [3:0]    k_q, k_d;
    logic          valid_q, valid_d;
    logic [3:0]    me_q, me_d;
    logic          rdy_q, rdy_d;

    logic          w_beat;
    logic          w_last;
    logic [31:0]   w_oct;
    logic [3:0]    w_k;
    logic [7:0]    w_cfg [16];

    for (genvar n = 0; n < 16; n++) begin : g_cfg
        if (n < 14) begin : g_oct
            assign w_cfg[n] = CFG[8*n +: 8];
        end else begin : g_pad
            assign w_cfg[n] = 8'h00;
        end
    end

    // Octet priority: /R/, /A/, /Q/, config window, ramp.
    for (genvar j = 0; j < 4; j++) begin : g_lane
        logic [IW-1:0] w_i;
        logic [3:0]    w_cidx;
        logic [7:0]    w_lane_oct;
        logic          w_lane_k;

        assign w_i    = IW'({b_q, 2'b00}) + IW'(j);
        assign w_cidx = w_i[3:0] - 4'd2;

        always_comb begin
            w_lane_oct = w_i[7:0];
            w_lane_k   = 1'b0;
            if (w_i == '0) begin
                w_lane_oct = 8'h1C;
                w_lane_k   = 1'b1;
            end else if (w_i == I_LAST) begin
                w_lane_oct = 8'h7C;
                w_lane_k   = 1'b1;
            end else if (m_q == MW'(1) && w_i == IW'(1)) begin
                w_lane_oct = 8'h9C;
                w_lane_k   = 1'b1;
            end else if (m_q == MW'(1) && w_i >= IW'(2) && w_i <= IW'(15)) begin
                w_lane_oct = w_cfg[w_cidx];
            end
        end

        assign w_oct[8*j +: 8] = w_lane_oct;
        assign w_k[j]          = w_lane_k;
    end

    assign w_beat = EN && (state_q == S_IDLE || state_q == S_RUN);
    assign w_last = (b_q == B_LAST) && (m_q == M_LAST);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= S_IDLE;
            b_q     <= '0;
            m_q     <= '0;
            data_q  <= '0;
            k_q     <= '0;
            valid_q <= 1'b0;
            me_q    <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            m_q     <= m_d;
            data_q  <= data_d;
            k_q     <= k_d;
            valid_q <= valid_d;
            me_q    <= me_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (EN) state_d = S_RUN;
            S_RUN: begin
                if (!EN)        state_d = S_IDLE;
                else if (w_last) state_d = S_DONE;
            end
            S_DONE: if (!EN) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Counters stay at zero except while beats are being produced.
    always_comb begin
        b_d     = '0;
        m_d     = '0;
        data_d  = '0;
        k_d     = '0;
        valid_d = 1'b0;
        me_d    = '0;
        rdy_d   = 1'b0;
        if (w_beat) begin
            data_d  = w_oct;
            k_d     = w_k;
            valid_d = 1'b1;
            rdy_d   = (m_q == M_LAST);
            me_d    = w_last ? 4'b1000 : 4'b0000;
            if (!w_last) begin
                if (b_q == B_LAST) begin
                    b_d = '0;
                    m_d = m_q + MW'(1);
                end else begin
                    b_d = b_q + BW'(1);
                    m_d = m_q;
                end
            end
        end
    end

    assign TX_DATA  = data_q;
    assign TX_K     = k_q;
    assign TX_VALID = valid_q;
    assign ILA_ME   = me_q;
    assign ILA_RDY  = rdy_q;

endmodule
`default_nettype wire

// File: tb/tb_ila_seq.sv
`default_nettype none
// ============================================================================
// tb_ila_seq : scoreboard bench for ila_seq (two parameter sets side by side)
// Rev 1.0
// ============================================================================
module tb_ila_seq;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  k;
        logic        valid;
        logic [3:0]  me;
        logic        rdy;
    } exp_t;

    logic         CLK;
    logic         RST_n;
    logic         EN;
    logic [111:0] CFG;

    logic [31:0] a_data, b_data;
    logic [3:0]  a_k, b_k, a_me, b_me;
    logic        a_valid, b_valid, a_rdy, b_rdy;

    int checks   = 0;
    int failures = 0;
    int vcnt_a   = 0;
    int vcnt_b   = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    int pos_a = 0, pos_b = 0;
    bit done_a = 0, done_b = 0;

    ila_seq #(.F(2), .K(16), .NUM_MF(4)) dut_a (
        .CLK(CLK), .RST_n(RST_n), .EN(EN), .CFG(CFG),
        .TX_DATA(a_data), .TX_K(a_k), .TX_VALID(a_valid),
        .ILA_ME(a_me), .ILA_RDY(a_rdy)
    );

    ila_seq #(.F(1), .K(20), .NUM_MF(4)) dut_b (
        .CLK(CLK), .RST_n(RST_n), .EN(EN), .CFG(CFG),
        .TX_DATA(b_data), .TX_K(b_k), .TX_VALID(b_valid),
        .ILA_ME(b_me), .ILA_RDY(b_rdy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Expected beat at sequence position pos, straight from the octet rules.
    function automatic exp_t model_beat(input int f, input int k, input int nmf,
                                        input int pos, input logic [111:0] cfg);
        exp_t e;
        int   mfo;
        int   mfb;
        int   m;
        int   b;
        mfo     = f * k;
        mfb     = mfo / 4;
        m       = pos / mfb;
        b       = pos % mfb;
        e       = '0;
        e.valid = 1'b1;
        e.rdy   = (m == nmf - 1);
        e.me    = (pos == mfb * nmf - 1) ? 4'h8 : 4'h0;
        for (int j = 0; j < 4; j++) begin
            int         i;
            logic [7:0] o;
            logic       kk;
            i  = 4 * b + j;
            kk = 1'b0;
            if (i == 0) begin
                o = 8'h1C; kk = 1'b1;
            end else if (i == mfo - 1) begin
                o = 8'h7C; kk = 1'b1;
            end else if (m == 1 && i == 1) begin
                o = 8'h9C; kk = 1'b1;
            end else if (m == 1 && i >= 2 && i <= 15) begin
                o = cfg[8*(i-2) +: 8];
            end else begin
                o = 8'(i % 256);
            end
            e.data[8*j +: 8] = o;
            e.k[j]           = kk;
        end
        return e;
    endfunction

    task automatic predict_one(input int f, input int k, input int nmf,
                               input logic rst_s, input logic en_s,
                               inout int pos, inout bit done, output exp_t e);
        int total;
        total = (f * k / 4) * nmf;
        e     = '0;
        if (!rst_s || !en_s) begin
            pos  = 0;
            done = 1'b0;
        end else if (!done) begin
            e   = model_beat(f, k, nmf, pos, CFG);
            pos = pos + 1;
            if (pos == total) begin
                done = 1'b1;
                pos  = 0;
            end
        end
    endtask

    task automatic cycle();
        exp_t e;
        @(posedge CLK);
        predict_one(2, 16, 4, RST_n, EN, pos_a, done_a, e);
        qa.push_back(e);
        predict_one(1, 20, 4, RST_n, EN, pos_b, done_b, e);
        qb.push_back(e);
        #1;
    endtask

    task automatic cmp(input string nm, input exp_t e, input logic [31:0] d,
                       input logic [3:0] kk, input logic v, input logic [3:0] me,
                       input logic r);
        checks++;
        if ({d, kk, v, me, r} !== {e.data, e.k, e.valid, e.me, e.rdy}) begin
            failures++;
            $display("FAIL %s @%0t: got data=%h k=%h v=%b me=%h rdy=%b, want data=%h k=%h v=%b me=%h rdy=%b",
                     nm, $time, d, kk, v, me, r, e.data, e.k, e.valid, e.me, e.rdy);
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, got, want);
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                cmp("beat_a", ea, a_data, a_k, a_valid, a_me, a_rdy);
                if (a_valid) vcnt_a++;
            end
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                cmp("beat_b", eb, b_data, b_k, b_valid, b_me, b_rdy);
                if (b_valid) vcnt_b++;
            end
        end
    end

    initial begin
        RST_n = 1'b0;
        EN    = 1'b0;
        CFG   = '0;
        repeat (3) cycle();
        chk("reset_a", {a_data, a_k, a_valid, a_me, a_rdy}, '0);
        RST_n = 1'b1;
        cycle();

        // Full sequence with CFG octet n = 0xA0+n, EN held through DONE.
        for (int n = 0; n < 14; n++) CFG[8*n +: 8] = 8'hA0 + 8'(n);
        vcnt_a = 0; vcnt_b = 0;
        EN = 1'b1;
        cycle();
        chk("first_beat", {a_data, a_k, a_valid}, {32'h0302011C, 4'h1, 1'b1});
        repeat (39) cycle();
        chk("count_a", 64'(vcnt_a), 64'd32);
        chk("count_b", 64'(vcnt_b), 64'd20);

        // Re-arm after one low cycle.
        EN = 1'b0;
        cycle();
        vcnt_a = 0; vcnt_b = 0;
        EN = 1'b1;
        repeat (40) cycle();
        chk("rearm_count_a", 64'(vcnt_a), 64'd32);
        chk("rearm_count_b", 64'(vcnt_b), 64'd20);

        // Abort after beat 10, then restart.
        EN = 1'b0;
        cycle();
        EN = 1'b1;
        repeat (11) cycle();
        EN = 1'b0;
        cycle();
        chk("abort_zero", {a_data, a_k, a_valid, a_me, a_rdy}, '0);
        EN = 1'b1;
        cycle();
        chk("abort_restart", {a_data, a_k, a_valid}, {32'h0302011C, 4'h1, 1'b1});

        // Asynchronous reset in multiframe 2.
        repeat (20) cycle();
        @(negedge CLK);
        #1 RST_n = 1'b0;
        #1;
        chk("async_rst_a", {a_data, a_k, a_valid, a_me, a_rdy}, '0);
        chk("async_rst_b", {b_data, b_k, b_valid, b_me, b_rdy}, '0);
        cycle();
        cycle();
        RST_n = 1'b1;
        cycle();
        chk("rst_restart", {a_data, a_k, a_valid}, {32'h0302011C, 4'h1, 1'b1});

        // Randomized configuration, run lengths and aborts.
        repeat (30) begin
            EN  = 1'b0;
            CFG = {$urandom, $urandom, $urandom, $urandom};
            repeat ($urandom_range(1, 3)) cycle();
            EN = 1'b1;
            repeat ($urandom_range(1, 45)) cycle();
        end

        EN = 1'b0;
        repeat (3) cycle();
        @(negedge CLK);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
